// File: rtl/mips_register_operand_unit_if.sv
// Bus between decode and the register operand unit: per-instruction register
// control fields, in-flight results, resolved operands, stall and commit view.
interface mips_register_operand_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  idValid;
    logic [ADDR_WIDTH-1:0] idRs;
    logic [ADDR_WIDTH-1:0] idRt;
    logic [ADDR_WIDTH-1:0] idRd;
    logic                  idPort1Src;
    logic                  idWriteAddrSrc;
    logic                  idWriteDataSrc;
    logic                  idWriteEnable;
    logic [DATA_WIDTH-1:0] exAluResult;
    logic [DATA_WIDTH-1:0] memLoadData;
    logic [DATA_WIDTH-1:0] port1Data;
    logic [DATA_WIDTH-1:0] port2Data;
    logic                  stall;
    logic                  wbValid;
    logic [ADDR_WIDTH-1:0] wbAddr;
    logic [DATA_WIDTH-1:0] wbData;

    modport master (
        output idValid, idRs, idRt, idRd, idPort1Src, idWriteAddrSrc,
               idWriteDataSrc, idWriteEnable, exAluResult, memLoadData,
        input  port1Data, port2Data, stall, wbValid, wbAddr, wbData
    );

    modport slave (
        input  idValid, idRs, idRt, idRd, idPort1Src, idWriteAddrSrc,
               idWriteDataSrc, idWriteEnable, exAluResult, memLoadData,
        output port1Data, port2Data, stall, wbValid, wbAddr, wbData
    );
endinterface

// File: rtl/mips_register_operand_unit.sv
// Register file with EX/MEM/WB destination tracking, operand forwarding,
// load-use stall detection and write-back commit.
module mips_register_operand_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    mips_register_operand_unit_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        logic  valid;
        logic  we;
        addr_t dest;
        logic  is_load;
    } ex_stage_t;

    typedef struct packed {
        logic  valid;
        logic  we;
        addr_t dest;
        logic  is_load;
        data_t alu_value;
    } mem_stage_t;

    typedef struct packed {
        logic  valid;
        logic  we;
        addr_t dest;
        data_t data;
    } wb_stage_t;

    ex_stage_t  ex_q;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;
    data_t      regs [NUM_REGS];

    addr_t port1_addr;
    addr_t port2_addr;
    addr_t id_dest;
    logic  id_we;
    data_t mem_value;

    assign port1_addr = bus.idPort1Src ? bus.idRt : bus.idRs;
    assign port2_addr = bus.idRt;
    assign id_dest    = bus.idWriteAddrSrc ? bus.idRd : bus.idRt;
    assign id_we      = bus.idValid & bus.idWriteEnable & (id_dest != '0);
    assign mem_value  = mem_q.is_load ? bus.memLoadData : mem_q.alu_value;

    // A load in EX has no data yet, so a consumer in ID must wait one cycle
    // until the load reaches MEM and can be forwarded from there.
    assign bus.stall = bus.idValid & ex_q.valid & ex_q.we & ex_q.is_load &
                       (ex_q.dest != '0) &
                       ((ex_q.dest == port1_addr) | (ex_q.dest == port2_addr));

    function automatic data_t resolve(
        input addr_t      a,
        input ex_stage_t  ex,
        input data_t      ex_value,
        input mem_stage_t mem,
        input data_t      mem_fwd,
        input wb_stage_t  wb,
        input data_t      file_value
    );
        if (a == '0)
            return '0;
        else if (ex.valid && ex.we && ex.dest == a && !ex.is_load)
            return ex_value;
        else if (mem.valid && mem.we && mem.dest == a)
            return mem_fwd;
        else if (wb.valid && wb.we && wb.dest == a)
            return wb.data;
        else
            return file_value;
    endfunction

    assign bus.port1Data = resolve(port1_addr, ex_q, bus.exAluResult, mem_q,
                                   mem_value, wb_q, regs[port1_addr]);
    assign bus.port2Data = resolve(port2_addr, ex_q, bus.exAluResult, mem_q,
                                   mem_value, wb_q, regs[port2_addr]);

    assign bus.wbValid = wb_q.valid & wb_q.we;
    assign bus.wbAddr  = wb_q.dest;
    assign bus.wbData  = wb_q.data;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge value of the stage before it, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q.valid      <= bus.idValid & ~bus.stall;
            ex_q.we         <= id_we & ~bus.stall;
            ex_q.dest       <= id_dest;
            ex_q.is_load    <= bus.idWriteDataSrc;

            mem_q.valid     <= ex_q.valid;
            mem_q.we        <= ex_q.we;
            mem_q.dest      <= ex_q.dest;
            mem_q.is_load   <= ex_q.is_load;
            mem_q.alu_value <= bus.exAluResult;

            wb_q.valid      <= mem_q.valid;
            wb_q.we         <= mem_q.we;
            wb_q.dest       <= mem_q.dest;
            wb_q.data       <= mem_value;
        end
    end

    // NOTE: the register file is reset on purpose: architectural state must read
    // zero after reset, which costs a reset on every entry instead of a RAM macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_q.valid && wb_q.we && wb_q.dest != '0) begin
            regs[wb_q.dest] <= wb_q.data;
        end
    end
endmodule

// File: tb/tb_mips_register_operand_unit.sv
// Directed bench for mips_register_operand_unit: stimulus pushes expected
// commits into a queue, a negedge monitor pops and compares each commit.
module tb_mips_register_operand_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [DW-1:0] JUNK_EX  = 32'hEEEE_0000;
    localparam logic [DW-1:0] JUNK_MEM = 32'hAAAA_0000;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } commit_t;

    logic    clock = 1'b0;
    logic    reset;
    commit_t expected_q [$];
    int      n_checks = 0;
    int      n_errors = 0;

    always #5 clock = ~clock;

    mips_register_operand_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mips_register_operand_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic drive_id(input logic v, input logic [AW-1:0] rs,
                            input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                            input logic p1src, input logic wasrc,
                            input logic wdsrc, input logic we);
        bus.idValid        = v;
        bus.idRs           = rs;
        bus.idRt           = rt;
        bus.idRd           = rd;
        bus.idPort1Src     = p1src;
        bus.idWriteAddrSrc = wasrc;
        bus.idWriteDataSrc = wdsrc;
        bus.idWriteEnable  = we;
    endtask

    task automatic alu_write(input logic [AW-1:0] rd);
        drive_id(1'b1, '0, '0, rd, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic load(input logic [AW-1:0] rt);
        drive_id(1'b1, '0, rt, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic read_regs(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        drive_id(1'b1, rs, rt, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive_id(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_commit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        commit_t c;
        c.addr = a;
        c.data = d;
        expected_q.push_back(c);
    endtask

    // Advance one cycle; in-flight data buses default to junk each cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        bus.exAluResult = JUNK_EX;
        bus.memLoadData = JUNK_MEM;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (bus.wbValid === 1'b1) begin
                if (expected_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: got commit addr %0d data %h, expected no commit",
                             bus.wbAddr, bus.wbData);
                end else begin
                    commit_t e;
                    e = expected_q.pop_front();
                    check("wb_addr", 32'(bus.wbAddr), 32'(e.addr));
                    check("wb_data", bus.wbData, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b1;
        idle();
        bus.exAluResult = JUNK_EX;
        bus.memLoadData = JUNK_MEM;
        @(posedge clock);
        #2;
        check("rst_port1", bus.port1Data, '0);
        check("rst_port2", bus.port2Data, '0);
        check("rst_stall", 32'(bus.stall), 0);
        check("rst_wb_valid", 32'(bus.wbValid), 0);
        check("rst_wb_addr", 32'(bus.wbAddr), 0);
        check("rst_wb_data", bus.wbData, '0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Reset mid-pipeline: $1 in MEM, $2 in EX, $4 in ID, then reset.
        alu_write(5'd1);
        tick();
        alu_write(5'd2);
        bus.exAluResult = 32'h0000_0111;
        tick();
        drive_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.exAluResult = 32'h0000_0222;
        settle();
        check("pre_reset_mem_fwd", bus.port1Data, 32'h0000_0111);
        check("pre_reset_ex_fwd", bus.port2Data, 32'h0000_0222);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_port1", bus.port1Data, '0);
        check("mid_reset_port2", bus.port2Data, '0);
        check("mid_reset_wb_valid", 32'(bus.wbValid), 0);
        check("mid_reset_stall", 32'(bus.stall), 0);
        idle();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        repeat (3) tick();
        read_regs(5'd1, 5'd2);
        settle();
        check("post_reset_r1", bus.port1Data, '0);
        check("post_reset_r2", bus.port2Data, '0);
        read_regs(5'd4, 5'd0);
        #1;
        check("post_reset_r4", bus.port1Data, '0);
        tick();

        // Back-to-back ALU dependency.
        alu_write(5'd3);
        expect_commit(5'd3, 32'h0000_0011);
        tick();
        read_regs(5'd3, 5'd0);
        bus.exAluResult = 32'h0000_0011;
        settle();
        check("alu_fwd_port1", bus.port1Data, 32'h0000_0011);
        check("alu_fwd_stall", 32'(bus.stall), 0);
        tick();
        idle();
        tick();
        tick();
        read_regs(5'd3, 5'd0);
        settle();
        check("alu_file_port1", bus.port1Data, 32'h0000_0011);
        tick();

        // Load-use on port 2: one stall cycle, then MEM forward.
        load(5'd5);
        expect_commit(5'd5, 32'hDEAD_BEEF);
        tick();
        drive_id(1'b1, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        check("load_use_stall", 32'(bus.stall), 1);
        tick();
        bus.memLoadData = 32'hDEAD_BEEF;
        settle();
        check("load_use_stall_released", 32'(bus.stall), 0);
        check("load_fwd_port2", bus.port2Data, 32'hDEAD_BEEF);
        expect_commit(5'd6, 32'hDEAD_BEEF);
        tick();
        idle();
        bus.exAluResult = 32'hDEAD_BEEF;
        repeat (3) tick();

        // Shift-source port 1 reads Rt; load into $7 stalls via Rt.
        alu_write(5'd7);
        expect_commit(5'd7, 32'h0000_0080);
        tick();
        idle();
        bus.exAluResult = 32'h0000_0080;
        repeat (3) tick();
        drive_id(1'b1, 5'd2, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("shift_port1", bus.port1Data, 32'h0000_0080);
        tick();
        load(5'd7);
        expect_commit(5'd7, 32'h0000_0099);
        tick();
        read_regs(5'd3, 5'd2);
        settle();
        check("unrelated_no_stall", 32'(bus.stall), 0);
        drive_id(1'b1, 5'd3, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("shift_load_stall", 32'(bus.stall), 1);
        tick();
        bus.memLoadData = 32'h0000_0099;
        settle();
        check("shift_load_stall_released", 32'(bus.stall), 0);
        check("shift_load_fwd", bus.port1Data, 32'h0000_0099);
        tick();
        idle();
        repeat (3) tick();

        // Register 0: writes are dropped and loads to $0 never stall.
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        read_regs(5'd0, 5'd0);
        bus.exAluResult = 32'h0000_1234;
        settle();
        check("zero_port1", bus.port1Data, '0);
        check("zero_port2", bus.port2Data, '0);
        tick();
        load(5'd0);
        tick();
        read_regs(5'd0, 5'd0);
        settle();
        check("zero_load_no_stall", 32'(bus.stall), 0);
        tick();
        idle();
        repeat (3) tick();
        read_regs(5'd0, 5'd0);
        settle();
        check("zero_file_port1", bus.port1Data, '0);
        tick();

        // Priority: EX over MEM over WB over file.
        alu_write(5'd9);
        expect_commit(5'd9, 32'h0000_000A);
        tick();
        alu_write(5'd9);
        expect_commit(5'd9, 32'h0000_000B);
        bus.exAluResult = 32'h0000_000A;
        tick();
        alu_write(5'd9);
        expect_commit(5'd9, 32'h0000_000C);
        bus.exAluResult = 32'h0000_000B;
        tick();
        read_regs(5'd9, 5'd0);
        bus.exAluResult = 32'h0000_000C;
        settle();
        check("prio_ex", bus.port1Data, 32'h0000_000C);
        tick();
        idle();
        repeat (3) tick();

        alu_write(5'd9);
        expect_commit(5'd9, 32'h0000_000A);
        tick();
        alu_write(5'd9);
        expect_commit(5'd9, 32'h0000_000B);
        bus.exAluResult = 32'h0000_000A;
        tick();
        idle();
        bus.exAluResult = 32'h0000_000B;
        tick();
        read_regs(5'd9, 5'd0);
        settle();
        check("prio_mem", bus.port1Data, 32'h0000_000B);
        tick();
        idle();
        repeat (3) tick();

        alu_write(5'd9);
        expect_commit(5'd9, 32'h0000_000A);
        tick();
        idle();
        bus.exAluResult = 32'h0000_000A;
        tick();
        tick();
        read_regs(5'd9, 5'd0);
        settle();
        check("write_through_wb", bus.port1Data, 32'h0000_000A);
        tick();
        read_regs(5'd9, 5'd0);
        settle();
        check("file_after_commit", bus.port1Data, 32'h0000_000A);
        tick();

        idle();
        repeat (4) tick();
        check("commits_drained", 32'(expected_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mips_register_operand_unit.md
# mips_register_operand_unit

Consumer of the per-instruction register control fields (port-1 source, write-address source, write-data source, write enable) produced in decode. Holds the 32-entry architectural register file and resolves both decode-stage operand addresses. Tracks each instruction's destination through EX, MEM and WB. Forwards in-flight results, detects load-use hazards, and commits write-back data in WB.

## Interface

Parameters:
- `DATA_WIDTH`, 32, register and operand width.
- `ADDR_WIDTH`, 5, register address width; 2^ADDR_WIDTH registers.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `idValid` in 1: ID holds a real instruction.
- `idRs`, `idRt`, `idRd` in ADDR_WIDTH: instruction register fields.
- `idPort1Src` in 1: 0 = Rs, 1 = Rt (shift-by-immediate forms).
- `idWriteAddrSrc` in 1: 0 = Rt, 1 = Rd.
- `idWriteDataSrc` in 1: 0 = ALU, 1 = memory (load).
- `idWriteEnable` in 1: instruction writes a register.
- `exAluResult` in DATA_WIDTH: ALU result of the instruction now in EX.
- `memLoadData` in DATA_WIDTH: load data of the instruction now in MEM.
- `port1Data`, `port2Data` out DATA_WIDTH: resolved operands for ID.
- `stall` out 1: load-use hazard; hold ID/IF, bubble into EX.
- `wbValid` out 1, `wbAddr` out ADDR_WIDTH, `wbData` out DATA_WIDTH: commit observation.

## Operation

- Address resolution in ID:
  - port-1 address = `idPort1Src` ? Rt : Rs.
  - port-2 address = Rt, always.
  - dest = `idWriteAddrSrc` ? Rd : Rt.
  - Effective write enable = `idValid & idWriteEnable & (dest != 0)`.
- Stage registers:
  - EX: valid, we, dest, isLoad.
  - MEM: same fields plus aluValue, captured from `exAluResult` on EX->MEM advance.
  - WB: valid, we, dest, data. data = MEM isLoad ? `memLoadData` : aluValue, captured on MEM->WB advance.
- Advance: every cycle EX->MEM and MEM->WB advance unconditionally. ID->EX loads the ID instruction, or a bubble (valid=0) when `stall`.
- Commit: at the edge ending a cycle in which WB valid & we, `regs[dest] <= data`. Register 0 is never written and always reads 0.
- Operand resolution per port, address a, in priority order:
  1. a == 0 -> 0.
  2. EX valid & we & dest==a & !isLoad -> `exAluResult`.
  3. MEM valid & we & dest==a -> MEM isLoad ? `memLoadData` : aluValue.
  4. WB valid & we & dest==a -> WB data (write-through).
  5. Otherwise regs[a].
- `stall` = `idValid` & EX valid & EX we & EX isLoad & (EX dest == port-1 address or EX dest == port-2 address), with that dest nonzero. Operand outputs are don't-care while `stall`=1.
- Stall lasts exactly one cycle per load-use pair. Next cycle the load is in MEM and is forwarded via rule 3.
- Instructions with `idValid`=0 enter EX as bubbles, never write, never forward.

## Timing

- Instruction in ID in cycle n: EX n+1, MEM n+2, WB n+3. `wbValid`/`wbAddr`/`wbData` asserted in n+3; regfile updated at the edge ending n+3.
- Operands and `stall` are combinational from ID inputs, stage state and `exAluResult`/`memLoadData` (same cycle).
- Reset (async, any time): all stage valid bits 0, regfile all 0, `stall`=0, `wbValid`=0, `wbAddr`=0, `wbData`=0. Port outputs read 0 until first commit. In-flight instructions are discarded, not committed.
- Simultaneous matches: the youngest stage wins (EX > MEM > WB > file).
- A WB commit and an ID read of the same register in one cycle: ID sees the new value.

## Test plan

- Reset mid-pipeline: three writes in flight, assert `reset` between edges -> outputs zero immediately; no commit occurs; reads of those registers return 0.
- Back-to-back ALU dependency: `addu $3,..` (EX result 0x00000011) followed by a read of $3 in ID -> `port1Data`=0x11 same cycle, `stall`=0. At n+3, `wbAddr`=3, `wbData`=0x11.
- Load-use: `lw $5` then a read of $5 on port 2 -> `stall`=1 for exactly one cycle. Next cycle, with `memLoadData`=0xDEADBEEF, `port2Data`=0xDEADBEEF. One bubble is visible (no `wbValid` in the corresponding slot).
- Shift source: `idPort1Src`=1, Rt=7, regs[7]=0x80 -> `port1Data`=0x80. A load into $7 in EX forces `stall` even when Rs≠7.
- Register 0: write enabled with dest 0, data 0x1234 -> `wbValid` shows no commit to 0; reads of $0 return 0. A load to $0 never stalls.
- Priority/write-through: $9 written in WB (0xA), MEM (0xB), EX (0xC) simultaneously -> `port1Data`=0xC. With the EX write absent -> 0xB. With only WB -> 0xA in the commit cycle.
